// File: rtl/uart_ctrl_pkg.sv
// Shared constants for the UART command framing controller: one-hot state
// encoding, error codes, default sync marker and the checksum helper.
package uart_ctrl_pkg;

  localparam logic [7:0] SYNC_BYTE_DEF = 8'hA5;

  // One-hot state encoding; o_busy is simply "not IDLE".
  localparam int         STATE_W    = 5;
  localparam logic [4:0] ST_IDLE    = 5'b00001;
  localparam logic [4:0] ST_LEN     = 5'b00010;
  localparam logic [4:0] ST_PAYLOAD = 5'b00100;
  localparam logic [4:0] ST_CSUM    = 5'b01000;
  localparam logic [4:0] ST_STREAM  = 5'b10000;

  localparam logic [1:0] ERR_NONE    = 2'b00;
  localparam logic [1:0] ERR_LEN     = 2'b01;
  localparam logic [1:0] ERR_CSUM    = 2'b10;
  localparam logic [1:0] ERR_TIMEOUT = 2'b11;

  // Frame checksum step: plain 8-bit sum, wrapping mod 256.
  function automatic logic [7:0] csum_add(input logic [7:0] acc, input logic [7:0] data);
    return acc + data;
  endfunction

endpackage

// File: rtl/uart_cmd_frame_ctrl_if.sv
// Payload stream from the framing controller to the cube-move sequencer.
interface uart_cmd_frame_ctrl_if;
  logic [7:0] cmd_data;
  logic       cmd_valid;
  logic       cmd_last;
  logic       cmd_ready;

  modport master (output cmd_data, output cmd_valid, output cmd_last, input cmd_ready);
  modport slave  (input cmd_data, input cmd_valid, input cmd_last, output cmd_ready);
endinterface

// File: rtl/cmd_payload_buf.sv
// Payload register file: synchronous write, asynchronous read.
module cmd_payload_buf #(
  parameter int AW = 4
) (
  input  logic          I_sys_clk,
  input  logic          I_rst_n,
  input  logic          wr_en,
  input  logic [AW-1:0] wr_addr,
  input  logic [7:0]    wr_data,
  input  logic [AW-1:0] rd_addr,
  output logic [7:0]    rd_data
);

  logic [7:0] mem_r [2**AW];

  // Store one payload byte per write strobe; reset wipes stale frames.
  always_ff @(posedge I_sys_clk or negedge I_rst_n) begin
    if (!I_rst_n) begin
      for (int i = 0; i < 2**AW; i++) begin
        mem_r[i] <= 8'h00;
      end
    end else if (wr_en) begin
      mem_r[wr_addr] <= wr_data;
    end
  end

  assign rd_data = mem_r[rd_addr];

endmodule

// File: rtl/uart_cmd_frame_ctrl.sv
// Framing controller: hunts for the sync byte, collects a length-prefixed
// checksummed frame and streams its payload to the move sequencer.
module uart_cmd_frame_ctrl
  import uart_ctrl_pkg::*;
#(
  parameter logic [7:0] SYNC_BYTE     = SYNC_BYTE_DEF,
  parameter int         MAX_LEN       = 16,
  parameter int         TIMEOUT_TICKS = 704
) (
  input  logic       I_sys_clk,
  input  logic       I_rst_n,
  input  logic       I_baud_tick,
  input  logic [7:0] I_rx_data,
  input  logic       I_rx_data_valid,
  uart_cmd_frame_ctrl_if.master cmd_if,
  output logic       o_frame_ok,
  output logic       o_frame_err,
  output logic [1:0] o_err_code,
  output logic       o_rx_overrun,
  output logic       o_busy
);

  localparam int PTR_W  = $clog2(MAX_LEN + 1);
  localparam int BUF_AW = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;
  localparam int TMO_W  = $clog2(TIMEOUT_TICKS + 1);

  localparam logic [7:0]       MAX_LEN_B = 8'(MAX_LEN);
  localparam logic [PTR_W-1:0] PTR_ZERO  = {PTR_W{1'b0}};
  localparam logic [PTR_W-1:0] PTR_ONE   = PTR_W'(1);
  localparam logic [TMO_W-1:0] TMO_ZERO  = {TMO_W{1'b0}};
  localparam logic [TMO_W-1:0] TMO_ONE   = TMO_W'(1);
  localparam logic [TMO_W-1:0] TMO_LAST  = TMO_W'(TIMEOUT_TICKS - 1);

  logic [STATE_W-1:0] state_r;
  logic [PTR_W-1:0]   len_r;
  logic [PTR_W-1:0]   wr_ptr_r;
  logic [PTR_W-1:0]   rd_ptr_r;
  logic [7:0]         sum_r;
  logic [TMO_W-1:0]   tmo_cnt_r;
  logic               frame_ok_r;
  logic               frame_err_r;
  logic [1:0]         err_code_r;
  logic               overrun_r;

  logic       in_frame_s;
  logic       tmo_expire_s;
  logic       len_bad_s;
  logic       wr_last_s;
  logic       rd_last_s;
  logic       cmd_valid_s;
  logic       handshake_s;
  logic       buf_wr_en_s;
  logic [7:0] rd_data_s;

  // Decode of state, length check, pointer ends and the timeout condition.
  always_comb begin
    in_frame_s   = (state_r == ST_LEN) || (state_r == ST_PAYLOAD) || (state_r == ST_CSUM);
    // A byte in the same cycle as the final tick keeps the frame alive.
    tmo_expire_s = in_frame_s && !I_rx_data_valid && I_baud_tick && (tmo_cnt_r == TMO_LAST);
    len_bad_s    = (I_rx_data == 8'h00) || (I_rx_data > MAX_LEN_B);
    wr_last_s    = (wr_ptr_r == (len_r - PTR_ONE));
    rd_last_s    = (rd_ptr_r == (len_r - PTR_ONE));
    cmd_valid_s  = (state_r == ST_STREAM);
    handshake_s  = cmd_valid_s && cmd_if.cmd_ready;
    buf_wr_en_s  = (state_r == ST_PAYLOAD) && I_rx_data_valid;
  end

  // Inter-byte timeout: counts baud ticks only while a frame is being collected.
  always_ff @(posedge I_sys_clk or negedge I_rst_n) begin
    if (!I_rst_n) begin
      tmo_cnt_r <= TMO_ZERO;
    end else if (!in_frame_s || I_rx_data_valid) begin
      tmo_cnt_r <= TMO_ZERO;
    end else if (I_baud_tick) begin
      tmo_cnt_r <= tmo_cnt_r + TMO_ONE;
    end else begin
      tmo_cnt_r <= tmo_cnt_r;
    end
  end

  // Frame FSM with checksum accumulator, pointers and status pulses.
  always_ff @(posedge I_sys_clk or negedge I_rst_n) begin
    if (!I_rst_n) begin
      state_r     <= ST_IDLE;
      len_r       <= PTR_ZERO;
      wr_ptr_r    <= PTR_ZERO;
      rd_ptr_r    <= PTR_ZERO;
      sum_r       <= 8'h00;
      frame_ok_r  <= 1'b0;
      frame_err_r <= 1'b0;
      err_code_r  <= ERR_NONE;
      overrun_r   <= 1'b0;
    end else begin
      frame_ok_r  <= 1'b0;
      frame_err_r <= 1'b0;
      overrun_r   <= 1'b0;
      case (state_r)
        ST_IDLE: begin
          if (I_rx_data_valid && (I_rx_data == SYNC_BYTE)) begin
            state_r <= ST_LEN;
          end
        end
        ST_LEN: begin
          if (I_rx_data_valid) begin
            if (len_bad_s) begin
              state_r     <= ST_IDLE;
              frame_err_r <= 1'b1;
              err_code_r  <= ERR_LEN;
            end else begin
              len_r    <= I_rx_data[PTR_W-1:0];
              sum_r    <= I_rx_data;
              wr_ptr_r <= PTR_ZERO;
              state_r  <= ST_PAYLOAD;
            end
          end else if (tmo_expire_s) begin
            state_r     <= ST_IDLE;
            frame_err_r <= 1'b1;
            err_code_r  <= ERR_TIMEOUT;
          end
        end
        ST_PAYLOAD: begin
          if (I_rx_data_valid) begin
            sum_r    <= csum_add(sum_r, I_rx_data);
            wr_ptr_r <= wr_ptr_r + PTR_ONE;
            if (wr_last_s) begin
              state_r <= ST_CSUM;
            end
          end else if (tmo_expire_s) begin
            state_r     <= ST_IDLE;
            frame_err_r <= 1'b1;
            err_code_r  <= ERR_TIMEOUT;
          end
        end
        ST_CSUM: begin
          if (I_rx_data_valid) begin
            if (csum_add(sum_r, I_rx_data) == 8'h00) begin
              frame_ok_r <= 1'b1;
              rd_ptr_r   <= PTR_ZERO;
              state_r    <= ST_STREAM;
            end else begin
              state_r     <= ST_IDLE;
              frame_err_r <= 1'b1;
              err_code_r  <= ERR_CSUM;
            end
          end else if (tmo_expire_s) begin
            state_r     <= ST_IDLE;
            frame_err_r <= 1'b1;
            err_code_r  <= ERR_TIMEOUT;
          end
        end
        ST_STREAM: begin
          // Bytes arriving while the buffer is being drained are discarded.
          overrun_r <= I_rx_data_valid;
          if (handshake_s) begin
            if (rd_last_s) begin
              state_r <= ST_IDLE;
            end else begin
              rd_ptr_r <= rd_ptr_r + PTR_ONE;
            end
          end
        end
        default: begin
          state_r <= ST_IDLE;
        end
      endcase
    end
  end

  cmd_payload_buf #(
    .AW (BUF_AW)
  ) u_buf (
    .I_sys_clk (I_sys_clk),
    .I_rst_n   (I_rst_n),
    .wr_en     (buf_wr_en_s),
    .wr_addr   (wr_ptr_r[BUF_AW-1:0]),
    .wr_data   (I_rx_data),
    .rd_addr   (rd_ptr_r[BUF_AW-1:0]),
    .rd_data   (rd_data_s)
  );

  // Stream data is gated by the state register so reset forces it to zero.
  assign cmd_if.cmd_valid = cmd_valid_s;
  assign cmd_if.cmd_data  = cmd_valid_s ? rd_data_s : 8'h00;
  assign cmd_if.cmd_last  = cmd_valid_s && rd_last_s;

  assign o_frame_ok   = frame_ok_r;
  assign o_frame_err  = frame_err_r;
  assign o_err_code   = err_code_r;
  assign o_rx_overrun = overrun_r;
  assign o_busy       = (state_r != ST_IDLE);

endmodule

// File: tb/tb_uart_cmd_frame_ctrl.sv
// Self-checking bench for uart_cmd_frame_ctrl: directed corner cases plus
// randomized frames checked against a frame-level reference model.
module tb_uart_cmd_frame_ctrl;

  localparam int MAX_LEN = 16;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       baud_tick = 1'b0;
  logic [7:0] rx_data = 8'h00;
  logic       rx_valid = 1'b0;
  logic       cmd_ready = 1'b1;
  int         ready_mode = 0;
  logic       frame_ok, frame_err, overrun, busy;
  logic [1:0] err_code;

  int n_checks = 0;
  int n_errors = 0;

  uart_cmd_frame_ctrl_if cmd_if();
  assign cmd_if.cmd_ready = cmd_ready;

  uart_cmd_frame_ctrl #(.SYNC_BYTE(8'hA5), .MAX_LEN(MAX_LEN), .TIMEOUT_TICKS(704)) dut (
    .I_sys_clk(clk), .I_rst_n(rst_n), .I_baud_tick(baud_tick), .I_rx_data(rx_data),
    .I_rx_data_valid(rx_valid), .cmd_if(cmd_if), .o_frame_ok(frame_ok),
    .o_frame_err(frame_err), .o_err_code(err_code), .o_rx_overrun(overrun), .o_busy(busy));

  always #5 clk = ~clk;

  task automatic chk_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    end
  endtask

  // ---------------- reference model (frame level) ----------------
  logic [7:0] mdl_frm_q[$];
  bit         mdl_hunt = 1'b1;
  int         exp_evt_q[$];      // 0 = frame ok, 1..3 = error code
  logic [8:0] exp_strm_q[$];     // {last, data}

  task automatic model_feed(input logic [7:0] b);
    int s;
    int n;
    if (mdl_hunt) begin
      if (b == 8'hA5) begin
        mdl_hunt = 1'b0;
        mdl_frm_q.delete();
      end
    end else begin
      mdl_frm_q.push_back(b);
      n = int'(mdl_frm_q[0]);
      if (mdl_frm_q.size() == 1 && (n == 0 || n > MAX_LEN)) begin
        exp_evt_q.push_back(1);
        mdl_hunt = 1'b1;
      end else if (mdl_frm_q.size() == n + 2) begin
        s = 0;
        foreach (mdl_frm_q[i]) s += int'(mdl_frm_q[i]);
        if (s % 256 == 0) begin
          exp_evt_q.push_back(0);
          for (int i = 1; i <= n; i++) exp_strm_q.push_back({(i == n), mdl_frm_q[i]});
        end else begin
          exp_evt_q.push_back(2);
        end
        mdl_hunt = 1'b1;
      end
    end
  endtask

  task automatic model_timeout();
    if (!mdl_hunt) begin
      exp_evt_q.push_back(3);
      mdl_hunt = 1'b1;
    end
  endtask

  task automatic model_reset();
    mdl_hunt = 1'b1;
    mdl_frm_q.delete();
    exp_strm_q.delete();
  endtask

  function automatic logic [7:0] mk_csum(input logic [7:0] q[$]);
    int s = 0;
    foreach (q[i]) s += int'(q[i]);
    return 8'((256 - (s % 256)) % 256);
  endfunction

  // ---------------- monitor ----------------
  logic       prev_valid = 1'b0, prev_ready = 1'b0, prev_last = 1'b0;
  logic [7:0] prev_data = 8'h00;

  always @(negedge clk) begin
    if (rst_n) begin
      if (frame_ok) begin
        if (exp_evt_q.size() == 0) chk_eq("evt_extra_ok", 32'd1, 32'd0);
        else chk_eq("evt_ok", 32'd0, 32'(exp_evt_q.pop_front()));
      end
      if (frame_err) begin
        if (exp_evt_q.size() == 0) chk_eq("evt_extra_err", 32'(err_code), 32'd0);
        else chk_eq("evt_err_code", 32'(err_code), 32'(exp_evt_q.pop_front()));
      end
      if (cmd_if.cmd_valid && cmd_ready) begin
        if (exp_strm_q.size() == 0) chk_eq("strm_extra", 32'(cmd_if.cmd_data), 32'h100);
        else chk_eq("strm_byte", 32'({cmd_if.cmd_last, cmd_if.cmd_data}), 32'(exp_strm_q.pop_front()));
      end
      if (prev_valid && !prev_ready && cmd_if.cmd_valid)
        chk_eq("strm_hold", 32'({cmd_if.cmd_last, cmd_if.cmd_data}), 32'({prev_last, prev_data}));
    end
    prev_valid <= cmd_if.cmd_valid;
    prev_ready <= cmd_ready;
    prev_last  <= cmd_if.cmd_last;
    prev_data  <= cmd_if.cmd_data;
  end

  // Downstream ready pattern: 0 always, 1 toggle, 2 random, other = stalled.
  initial begin
    forever begin
      @(posedge clk); #1;
      case (ready_mode)
        0: cmd_ready = 1'b1;
        1: cmd_ready = ~cmd_ready;
        2: cmd_ready = 1'($urandom_range(0, 1));
        default: cmd_ready = 1'b0;
      endcase
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic send_byte(input logic [7:0] b, input bit feed, input bit tk);
    @(posedge clk); #1;
    rx_valid = 1'b1; rx_data = b; baud_tick = tk;
    @(posedge clk); #1;
    rx_valid = 1'b0; baud_tick = 1'b0;
    if (feed) model_feed(b);
  endtask

  task automatic idle_cycles(input int n);
    repeat (n) begin
      @(posedge clk); #1;
      baud_tick = ($urandom_range(0, 3) == 0);
    end
    baud_tick = 1'b0;
  endtask

  task automatic tick_cycles(input int n);
    repeat (n) begin
      baud_tick = 1'b1;
      @(posedge clk); #1;
    end
    baud_tick = 1'b0;
  endtask

  task automatic send_frame(input logic [7:0] frm[$], input bit rnd);
    logic [7:0] q[$];
    q = frm;
    q.push_front(8'hA5);
    foreach (q[i]) begin
      if (rnd) idle_cycles($urandom_range(0, 3));
      send_byte(q[i], 1'b1, rnd ? ($urandom_range(0, 3) == 0) : 1'b0);
    end
  endtask

  task automatic wait_idle(input int budget);
    int cnt = 0;
    baud_tick = 1'b0;
    do begin
      @(negedge clk);
      cnt++;
    end while (busy && cnt < budget);
    chk_eq("idle_wait", 32'(busy), 32'd0);
  endtask

  task automatic chk_outputs_zero(input string tag);
    chk_eq({tag, "_valid"}, 32'(cmd_if.cmd_valid), 32'd0);
    chk_eq({tag, "_data"},  32'(cmd_if.cmd_data),  32'd0);
    chk_eq({tag, "_last"},  32'(cmd_if.cmd_last),  32'd0);
    chk_eq({tag, "_ok"},    32'(frame_ok),         32'd0);
    chk_eq({tag, "_err"},   32'(frame_err),        32'd0);
    chk_eq({tag, "_code"},  32'(err_code),         32'd0);
    chk_eq({tag, "_ovr"},   32'(overrun),          32'd0);
    chk_eq({tag, "_busy"},  32'(busy),             32'd0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  // ---------------- main sequence ----------------
  initial begin
    logic [7:0] frm[$];
    logic [7:0] g;
    int kind, n;

    repeat (3) @(negedge clk);
    chk_outputs_zero("reset");
    @(posedge clk); #1;
    rst_n = 1'b1;

    // Good frame with checksum derived from the rule, ready held high.
    ready_mode = 0;
    frm = '{8'h03, 8'h11, 8'h22, 8'h33};
    frm.push_back(mk_csum(frm));
    send_frame(frm, 1'b0);
    @(negedge clk);
    chk_eq("good_ok", 32'(frame_ok), 32'd1);
    chk_eq("good_b0", 32'({cmd_if.cmd_valid, cmd_if.cmd_last, cmd_if.cmd_data}), 32'h211);
    @(negedge clk);
    chk_eq("good_b1", 32'({cmd_if.cmd_valid, cmd_if.cmd_last, cmd_if.cmd_data}), 32'h222);
    @(negedge clk);
    chk_eq("good_b2", 32'({cmd_if.cmd_valid, cmd_if.cmd_last, cmd_if.cmd_data}), 32'h333);
    @(negedge clk);
    chk_eq("good_done_valid", 32'(cmd_if.cmd_valid), 32'd0);
    chk_eq("good_done_busy", 32'(busy), 32'd0);

    // 0x87 does not zero the sum 03+11+22+33, so it is a checksum error.
    frm = '{8'h03, 8'h11, 8'h22, 8'h33, 8'h87};
    send_frame(frm, 1'b0);
    @(negedge clk);
    chk_eq("csum87_code", 32'(err_code), 32'd2);

    // Backpressure with toggling ready.
    ready_mode = 1;
    frm = '{8'h03, 8'h11, 8'h22, 8'h33};
    frm.push_back(mk_csum(frm));
    send_frame(frm, 1'b0);
    wait_idle(100);
    ready_mode = 0;

    // Bad checksum followed by a good one-byte frame.
    frm = '{8'h02, 8'h10, 8'h20, 8'h00};
    send_frame(frm, 1'b0);
    @(negedge clk);
    chk_eq("badcs_err", 32'(frame_err), 32'd1);
    chk_eq("badcs_code", 32'(err_code), 32'd2);
    chk_eq("badcs_valid", 32'(cmd_if.cmd_valid), 32'd0);
    frm = '{8'h01, 8'h05, 8'hFA};
    send_frame(frm, 1'b0);
    @(negedge clk);
    chk_eq("one_ok", 32'(frame_ok), 32'd1);
    chk_eq("one_b0", 32'({cmd_if.cmd_valid, cmd_if.cmd_last, cmd_if.cmd_data}), 32'h305);
    chk_eq("code_held", 32'(err_code), 32'd2);
    wait_idle(20);

    // Bad lengths: zero and MAX_LEN+1, then leftover bytes are ignored.
    frm = '{8'h00};
    send_frame(frm, 1'b0);
    @(negedge clk);
    chk_eq("len0_err", 32'({frame_err, err_code, busy}), 32'b1010);
    frm = '{8'h11};
    send_frame(frm, 1'b0);
    @(negedge clk);
    chk_eq("len17_err", 32'({frame_err, err_code, busy}), 32'b1010);
    send_byte(8'h01, 1'b1, 1'b0);
    send_byte(8'h05, 1'b1, 1'b0);
    send_byte(8'hFA, 1'b1, 1'b0);
    @(negedge clk);
    chk_eq("hunt_busy", 32'(busy), 32'd0);

    // Timeout after exactly 704 silent ticks.
    frm = '{8'h04, 8'h01};
    send_frame(frm, 1'b0);
    tick_cycles(703);
    @(negedge clk);
    chk_eq("tmo_703_alive", 32'({frame_err, busy}), 32'b01);
    tick_cycles(1);
    model_timeout();
    @(negedge clk);
    chk_eq("tmo_704_err", 32'({frame_err, err_code, busy}), 32'b1110);

    // A byte on the 704th tick keeps the frame alive.
    frm = '{8'h04, 8'h01};
    send_frame(frm, 1'b0);
    tick_cycles(703);
    send_byte(8'h02, 1'b1, 1'b1);
    @(negedge clk);
    chk_eq("tmo_byte_alive", 32'({frame_err, busy}), 32'b01);
    tick_cycles(703);
    @(negedge clk);
    chk_eq("tmo_rearm_alive", 32'({frame_err, busy}), 32'b01);
    send_byte(8'h03, 1'b1, 1'b0);
    send_byte(8'h04, 1'b1, 1'b0);
    send_byte(8'hF2, 1'b1, 1'b0);
    @(negedge clk);
    chk_eq("tmo_frame_ok", 32'(frame_ok), 32'd1);
    wait_idle(20);

    // Overrun while stalled: bytes dropped, stream unaffected.
    ready_mode = 3;
    frm = '{8'h02, 8'hAA, 8'hBB};
    frm.push_back(mk_csum(frm));
    send_frame(frm, 1'b0);
    @(negedge clk);
    chk_eq("ovr_stream_b0", 32'({cmd_if.cmd_valid, cmd_if.cmd_data}), 32'h1AA);
    send_byte(8'hA5, 1'b0, 1'b0);
    @(negedge clk);
    chk_eq("ovr_pulse", 32'(overrun), 32'd1);
    chk_eq("ovr_stream_hold", 32'({cmd_if.cmd_valid, cmd_if.cmd_data}), 32'h1AA);
    @(negedge clk);
    chk_eq("ovr_pulse_end", 32'(overrun), 32'd0);
    ready_mode = 0;
    wait_idle(20);

    // Randomized frames against the model.
    for (int f = 0; f < 40; f++) begin
      ready_mode = $urandom_range(0, 2);
      kind = $urandom_range(0, 3);
      repeat ($urandom_range(0, 2)) begin
        g = 8'($urandom_range(0, 255));
        if (g == 8'hA5) g = 8'h5A;
        send_byte(g, 1'b1, 1'b0);
      end
      frm.delete();
      if (kind == 2) begin
        n = ($urandom_range(0, 1) == 0) ? 0 : $urandom_range(17, 255);
        frm.push_back(8'(n));
      end else begin
        n = (kind == 3) ? MAX_LEN : $urandom_range(1, MAX_LEN);
        frm.push_back(8'(n));
        repeat (n) frm.push_back(8'($urandom_range(0, 255)));
        g = mk_csum(frm);
        if (kind == 1) g = g + 8'($urandom_range(1, 255));
        frm.push_back(g);
      end
      send_frame(frm, 1'b1);
      wait_idle(600);
    end

    // Reset mid-stream clears outputs at once.
    ready_mode = 3;
    frm = '{8'h02, 8'h11, 8'h22};
    frm.push_back(mk_csum(frm));
    send_frame(frm, 1'b0);
    @(negedge clk);
    chk_eq("rst_pre_valid", 32'(cmd_if.cmd_valid), 32'd1);
    @(posedge clk); #3;
    rst_n = 1'b0;
    model_reset();
    #1;
    chk_outputs_zero("rst_mid");
    @(posedge clk); #1;
    rst_n = 1'b1;
    ready_mode = 0;
    frm = '{8'h01, 8'h5C};
    frm.push_back(mk_csum(frm));
    send_frame(frm, 1'b0);
    wait_idle(20);

    chk_eq("evt_left", 32'(exp_evt_q.size()), 32'd0);
    chk_eq("strm_left", 32'(exp_strm_q.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
